// File: rtl/reshape_input_if.sv
// Handshake bundle for the reshape_input deserialiser: serial word stream in, parallel frame out.
// The slave modport is the deserialiser; the master modport is whatever drives and drains it.
interface reshape_input_if #(
    parameter int N_WORDS = 40,
    parameter int W       = 16
);
    logic [W-1:0] in  [1];
    logic         s_valid;
    logic         s_ready;
    logic         s_last;
    logic [W-1:0] out [N_WORDS];
    logic         m_valid;
    logic         m_ready;
    logic         err_short;
    logic         err_long;

    modport slave (
        input  in, s_valid, s_last, m_ready,
        output s_ready, out, m_valid, err_short, err_long
    );

    modport master (
        output in, s_valid, s_last, m_ready,
        input  s_ready, out, m_valid, err_short, err_long
    );
endinterface

// File: rtl/reshape_input.sv
// Serial-to-parallel frame collector: packs s_last-framed W-bit words into an N_WORDS vector,
// zero-padding short frames and dropping the surplus of long ones, with one-cycle error pulses.
module reshape_input #(
    parameter int N_WORDS = 40,
    parameter int W       = 16
) (
    input  logic            clk,
    input  logic            reset,
    reshape_input_if.slave  bus
);
    localparam int                IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_WORDS - 1);

    typedef enum logic [1:0] {FILL, DISCARD, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     bank_q [N_WORDS];
    logic [W-1:0]     bank_d [N_WORDS];
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;

    assign bus.s_ready   = (state_q != HOLD);
    assign bus.m_valid   = (state_q == HOLD);
    assign bus.err_short = err_short_q;
    assign bus.err_long  = err_long_q;

    for (genvar g = 0; g < N_WORDS; g++) begin : g_out
        assign bus.out[g] = bank_q[g];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bank_d      = bank_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        case (state_q)
            FILL: if (bus.s_valid) begin
                // s_last on a word before the final slot clears every later slot on the same edge
                for (int j = 0; j < N_WORDS; j++) begin
                    if (IDX_W'(j) == idx_q)
                        bank_d[j] = bus.in[0];
                    else if (bus.s_last && (IDX_W'(j) > idx_q))
                        bank_d[j] = '0;
                end
                if (bus.s_last) begin
                    state_d     = HOLD;
                    err_short_d = (idx_q != LAST_IDX);
                end else if (idx_q == LAST_IDX) begin
                    state_d    = DISCARD;
                    err_long_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DISCARD: if (bus.s_valid && bus.s_last) state_d = HOLD;
            HOLD: if (bus.m_ready) begin
                state_d = FILL;
                idx_d   = '0;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            idx_q       <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            for (int j = 0; j < N_WORDS; j++) bank_q[j] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            bank_q      <= bank_d;
        end
    end
endmodule

// File: tb/tb_reshape_input.sv
// Scoreboard bench for reshape_input: frames are modelled as they are driven and compared,
// together with the error pulses seen since the previous frame, when the DUT hands them off.
module tb_reshape_input;
    localparam int N = 40;
    localparam int W = 16;

    typedef logic [N-1:0][W-1:0] frame_t;
    typedef logic [W-1:0]        wq_t [$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reshape_input_if #(.N_WORDS(N), .W(W)) bus ();

    reshape_input #(.N_WORDS(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int     n_pass = 0;
    int     n_total = 0;
    frame_t exp_q [$];
    logic [1:0] err_q [$];   // {long, short}
    int     cnt_s = 0;
    int     cnt_l = 0;

    task automatic check(input string tag, input frame_t got, input frame_t exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic frame_t flat_out();
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = bus.out[i];
        return f;
    endfunction

    function automatic wq_t seq(input int base, input int n);
        wq_t q;
        for (int i = 0; i < n; i++) q.push_back(W'(base + i));
        return q;
    endfunction

    function automatic frame_t model(input wq_t words);
        frame_t e = '0;
        for (int k = 0; k < words.size() && k < N; k++) e[k] = words[k];
        return e;
    endfunction

    // Output side: a transfer is seen at the negedge before the posedge that commits it.
    always @(negedge clk) begin
        frame_t     e;
        logic [1:0] ee;
        if (reset) begin
            cnt_s = 0;
            cnt_l = 0;
        end else begin
            if (bus.err_short) cnt_s++;
            if (bus.err_long)  cnt_l++;
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_frame", frame_t'(1), frame_t'(0));
                end else begin
                    e  = exp_q.pop_front();
                    ee = err_q.pop_front();
                    check("frame", flat_out(), e);
                    check("err_short_cnt", frame_t'(cnt_s), frame_t'(ee[0]));
                    check("err_long_cnt", frame_t'(cnt_l), frame_t'(ee[1]));
                end
                cnt_s = 0;
                cnt_l = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the word was accepted.
    task automatic put(input logic [W-1:0] w, input logic last);
        int n = 0;
        bus.in[0]   = w;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        while (!bus.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) check("s_ready_timeout", frame_t'(0), frame_t'(1));
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input wq_t words, input bit gap);
        int n = words.size();
        exp_q.push_back(model(words));
        err_q.push_back({n > N, n < N});
        for (int k = 0; k < n; k++) begin
            put(words[k], k == n - 1);
            if (gap && k != n - 1) @(negedge clk);
        end
    endtask

    task automatic set_m_ready(input logic v);
        @(posedge clk);
        #1 bus.m_ready = v;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", frame_t'(exp_q.size()), frame_t'(0));
    endtask

    initial begin
        frame_t e;
        bus.in[0]   = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", flat_out(), frame_t'(0));
        check("rst_m_valid", frame_t'(bus.m_valid), frame_t'(0));
        check("rst_s_ready", frame_t'(bus.s_ready), frame_t'(1));
        check("rst_errs", frame_t'({bus.err_short, bus.err_long}), frame_t'(0));
        reset = 1'b0;
        @(negedge clk);

        // Nominal with m_ready held high
        set_m_ready(1'b1);
        send_frame(seq(1, 40), 1'b0);
        check("nom_m_valid_after_last", frame_t'(bus.m_valid), frame_t'(1));
        drain();
        @(negedge clk);
        check("nom_m_valid_one_cycle", frame_t'(bus.m_valid), frame_t'(0));
        check("nom_s_ready_back", frame_t'(bus.s_ready), frame_t'(1));

        // Backpressure
        set_m_ready(1'b0);
        send_frame(seq(1, 40), 1'b0);
        e = model(seq(1, 40));
        for (int c = 0; c < 10; c++) begin
            check("bp_m_valid", frame_t'(bus.m_valid), frame_t'(1));
            check("bp_s_ready", frame_t'(bus.s_ready), frame_t'(0));
            check("bp_out", flat_out(), e);
            @(negedge clk);
        end
        set_m_ready(1'b1);
        drain();

        // Short frame, then single-word frame
        send_frame(seq(16'hA000, 5), 1'b0);
        drain();
        send_frame(seq(16'h5A5A, 1), 1'b0);
        drain();

        // Long frame
        send_frame(seq(1, 43), 1'b0);
        check("long_m_valid_after_43", frame_t'(bus.m_valid), frame_t'(1));
        drain();

        // Gapped input
        send_frame(seq(1, 40), 1'b1);
        drain();

        // Reset after 20 words, then a clean frame
        send_frame(seq(100, 40), 1'b0);
        drain();
        for (int k = 0; k < 20; k++) put(W'(16'h7700 + k), 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out", flat_out(), frame_t'(0));
        check("mid_rst_m_valid", frame_t'(bus.m_valid), frame_t'(0));
        check("mid_rst_s_ready", frame_t'(bus.s_ready), frame_t'(1));
        reset = 1'b0;
        @(negedge clk);
        send_frame(seq(1, 40), 1'b0);
        drain();

        repeat (5) @(negedge clk);
        check("leftover_expected", frame_t'(exp_q.size()), frame_t'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
